// File: rtl/ialu_rvm_iter.sv
// ialu_rvm_iter: iterative RV32M/RV64M multiply/divide unit.
// A shared 2*XLEN shift register serves both the radix-2^MUL_BITS multiplier
// (high half = partial sum, low half = remaining multiplier digits) and the
// restoring divider (high half = partial remainder, low half = dividend/quotient).
module ialu_rvm_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rvm_cmd_vd_i,
  input  logic [2:0]      rvm_cmd_i,
  input  logic [XLEN-1:0] rvm_op1_i,
  input  logic [XLEN-1:0] rvm_op2_i,
  input  logic            rvm_flush_i,
  output logic [XLEN-1:0] rvm_res_o,
  output logic            rvm_res_rdy_o,
  output logic            rvm_busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BITS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;

  // operand conditioning
  logic              sgn1_en, sgn2_en;
  logic              op1_neg, op2_neg;
  logic [XLEN-1:0]   op1_abs, op2_abs;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   spec_res;

  // iteration datapath
  logic [MUL_BITS-1:0]      digit;
  logic [XLEN+MUL_BITS-1:0] mul_sum;
  logic [2*XLEN-1:0]        mul_next, div_next, step, prod_fix;
  logic [XLEN:0]            div_shift;
  logic                     div_ge;
  logic [XLEN-1:0]          div_rem, calc_res;

  // Decode which operands are treated as signed for the incoming command.
  always_comb begin
    sgn1_en = 1'b0;
    sgn2_en = 1'b0;
    case (rvm_cmd_i)
      3'b001:         begin sgn1_en = 1'b1; sgn2_en = 1'b1; end
      3'b010:         begin sgn1_en = 1'b1; sgn2_en = 1'b0; end
      3'b100, 3'b110: begin sgn1_en = 1'b1; sgn2_en = 1'b1; end
      default:        begin sgn1_en = 1'b0; sgn2_en = 1'b0; end
    endcase
  end

  assign op1_neg  = sgn1_en & rvm_op1_i[XLEN-1];
  assign op2_neg  = sgn2_en & rvm_op2_i[XLEN-1];
  assign op1_abs  = op1_neg ? (ZERO - rvm_op1_i) : rvm_op1_i;
  assign op2_abs  = op2_neg ? (ZERO - rvm_op2_i) : rvm_op2_i;
  assign div_zero = (rvm_op2_i == ZERO);
  assign div_ovf  = (rvm_cmd_i == 3'b100 || rvm_cmd_i == 3'b110) &&
                    (rvm_op1_i == MOST_NEG) && (rvm_op2_i == ALL_ONES);
  // cmd[1] distinguishes REM/REMU from DIV/DIVU
  assign spec_res = div_zero ? (rvm_cmd_i[1] ? rvm_op1_i : ALL_ONES)
                             : (rvm_cmd_i[1] ? ZERO : rvm_op1_i);

  // One multiply digit step and one restoring-divide step on the shared register.
  always_comb begin
    digit     = prod_q[MUL_BITS-1:0];
    mul_sum   = {{MUL_BITS{1'b0}}, prod_q[2*XLEN-1:XLEN]} +
                ({{MUL_BITS{1'b0}}, opb_q} * {{XLEN{1'b0}}, digit});
    mul_next  = {mul_sum, prod_q[XLEN-1:MUL_BITS]};
    div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_rem   = div_ge ? (div_shift[XLEN-1:0] - opb_q) : div_shift[XLEN-1:0];
    div_next  = {div_rem, prod_q[XLEN-2:0], div_ge};
    step      = cmd_q[2] ? div_next : mul_next;
  end

  // Sign-correct the last step and pick the architectural result half.
  always_comb begin
    prod_fix = {(2*XLEN){1'b0}};
    calc_res = ZERO;
    if (cmd_q[2]) begin
      if (cmd_q[1]) begin
        calc_res = neg_q ? (ZERO - step[2*XLEN-1:XLEN]) : step[2*XLEN-1:XLEN];
      end else begin
        calc_res = neg_q ? (ZERO - step[XLEN-1:0]) : step[XLEN-1:0];
      end
    end else begin
      prod_fix = neg_q ? ({(2*XLEN){1'b0}} - step) : step;
      if (cmd_q[1:0] == 2'b00) begin
        calc_res = prod_fix[XLEN-1:0];
      end else begin
        calc_res = prod_fix[2*XLEN-1:XLEN];
      end
    end
  end

  // Control FSM and next-state values for all registers; flush overrides everything.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    opb_d   = opb_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (rvm_cmd_vd_i && !rvm_flush_i) begin
          cmd_d = rvm_cmd_i;
          // remainder takes the dividend sign, everything else sign1^sign2
          neg_d = (rvm_cmd_i[2] && rvm_cmd_i[1]) ? op1_neg : (op1_neg ^ op2_neg);
          if (rvm_cmd_i[2]) begin
            opb_d  = op2_abs;
            prod_d = {ZERO, op1_abs};
            cnt_d  = DIV_LAST;
          end else begin
            opb_d  = op1_abs;
            prod_d = {ZERO, op2_abs};
            cnt_d  = MUL_LAST;
          end
          if (rvm_cmd_i[2] && (div_zero || div_ovf)) begin
            res_d   = spec_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        prod_d = step;
        if (cnt_q == {CW{1'b0}}) begin
          res_d   = calc_res;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (rvm_flush_i) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end else begin
      state_d = state_d;
    end
    rdy_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= 3'b000;
      opb_q   <= ZERO;
      prod_q  <= {(2*XLEN){1'b0}};
      cnt_q   <= {CW{1'b0}};
      neg_q   <= 1'b0;
      res_q   <= ZERO;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      opb_q   <= opb_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign rvm_res_o     = res_q;
  assign rvm_res_rdy_o = rdy_q;
  assign rvm_busy_o    = busy_q;

endmodule

// File: tb/tb_ialu_rvm_iter.sv
// Self-checking bench for ialu_rvm_iter: fixed vectors on the default
// 32-bit / radix-4 instance, flush and reset sequences, and random commands
// on two 64-bit instances (MUL_BITS 8 and 1) against a reference model.
module tb_ialu_rvm_iter;

  logic clk;
  logic rst_n;

  // default instance
  logic        vd, flush, rdy, busy;
  logic [2:0]  cmd;
  logic [31:0] op1, op2, res;

  // 64-bit instances
  logic        vd8, vd1, flush64, rdy8, rdy1, busy8, busy1;
  logic [2:0]  cmd64;
  logic [63:0] a64, b64, res8, res1;

  int checks = 0;
  int errors = 0;

  logic [31:0] q32[$];
  logic [63:0] q64[$];
  logic [31:0] last_exp = 32'h0;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[18];

  ialu_rvm_iter #(.XLEN(32), .MUL_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .rvm_cmd_vd_i(vd), .rvm_cmd_i(cmd),
    .rvm_op1_i(op1), .rvm_op2_i(op2), .rvm_flush_i(flush),
    .rvm_res_o(res), .rvm_res_rdy_o(rdy), .rvm_busy_o(busy));

  ialu_rvm_iter #(.XLEN(64), .MUL_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .rvm_cmd_vd_i(vd8), .rvm_cmd_i(cmd64),
    .rvm_op1_i(a64), .rvm_op2_i(b64), .rvm_flush_i(flush64),
    .rvm_res_o(res8), .rvm_res_rdy_o(rdy8), .rvm_busy_o(busy8));

  ialu_rvm_iter #(.XLEN(64), .MUL_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rvm_cmd_vd_i(vd1), .rvm_cmd_i(cmd64),
    .rvm_op1_i(a64), .rvm_op2_i(b64), .rvm_flush_i(flush64),
    .rvm_res_o(res1), .rvm_res_rdy_o(rdy1), .rvm_busy_o(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV64M reference model
  function automatic logic [63:0] ref64(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] xa, xb, p;
    logic signed [63:0] sa, sb, sr;
    sa = a;
    sb = b;
    if (!c[2]) begin
      xa = (c == 3'b001 || c == 3'b010) ? {{64{a[63]}}, a} : {64'd0, a};
      xb = (c == 3'b001) ? {{64{b[63]}}, b} : {64'd0, b};
      p  = xa * xb;
      return (c == 3'b000) ? p[63:0] : p[127:64];
    end
    if (b == 64'd0) return c[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (!c[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      return c[1] ? 64'd0 : a;
    case (c)
      3'b100:  sr = sa / sb;
      3'b110:  sr = sa % sb;
      3'b101:  return a / b;
      default: return a % b;
    endcase
    return sr;
  endfunction

  // Drive one command on the 32-bit instance, wait for rdy, compare.
  task automatic issue32(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat);
    int n;
    logic [31:0] exp;
    @(negedge clk);
    cmd = c; op1 = a; op2 = b; vd = 1'b1;
    q32.push_back(e);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_c0 cmd=%0d got %b want 0", c, busy);
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL busy_c1 cmd=%0d got %b want 1", c, busy);
        end
      end
    end while (rdy !== 1'b1 && n < 200);
    vd = 1'b0;
    exp = q32.pop_front();
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL timeout32 cmd=%0d no rdy after %0d cycles", c, n);
    end else if (res !== exp) begin
      errors++; $display("FAIL res32 cmd=%0d a=%h b=%h got %h want %h", c, a, b, res, exp);
    end
    checks++;
    if (n != lat) begin
      errors++; $display("FAIL lat32 cmd=%0d got %0d want %0d", c, n, lat);
    end
    last_exp = exp;
    @(posedge clk); #1;
    checks++;
    if (rdy !== 1'b0 || busy !== 1'b0 || res !== exp) begin
      errors++; $display("FAIL after32 cmd=%0d rdy=%b busy=%b res=%h want 0 0 %h", c, rdy, busy, res, exp);
    end
  endtask

  // Drive one command on a 64-bit instance (sel=0: MUL_BITS 8, sel=1: MUL_BITS 1).
  task automatic issue64(input bit sel, input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
    int n, lat;
    logic [63:0] exp, got;
    logic r;
    @(negedge clk);
    cmd64 = c; a64 = a; b64 = b;
    if (sel) vd1 = 1'b1; else vd8 = 1'b1;
    q64.push_back(ref64(c, a, b));
    if (c[2]) begin
      lat = (b == 64'd0 || (!c[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)) ? 1 : 65;
    end else begin
      lat = sel ? 65 : 9;
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      r = sel ? rdy1 : rdy8;
    end while (r !== 1'b1 && n < 200);
    vd1 = 1'b0; vd8 = 1'b0;
    got = sel ? res1 : res8;
    exp = q64.pop_front();
    checks++;
    if (r !== 1'b1) begin
      errors++; $display("FAIL timeout64 sel=%0d cmd=%0d", sel, c);
    end else if (got !== exp) begin
      errors++; $display("FAIL res64 sel=%0d cmd=%0d a=%h b=%h got %h want %h", sel, c, a, b, got, exp);
    end
    checks++;
    if (n != lat) begin
      errors++; $display("FAIL lat64 sel=%0d cmd=%0d got %0d want %0d", sel, c, n, lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    logic [2:0]  rc;
    logic [63:0] ra, rb;

    vecs[0]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 17};
    vecs[1]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 17};
    vecs[2]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 17};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 17};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[12] = '{3'b001, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 17};
    vecs[13] = '{3'b000, 32'h12345678, 32'h00000009, 32'hA3D70A38, 17};
    vecs[14] = '{3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33};
    vecs[15] = '{3'b110, 32'd20,       32'hFFFFFFFD, 32'h00000002, 33};
    vecs[16] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};
    vecs[17] = '{3'b011, 32'h80000000, 32'd2,        32'h00000001, 17};

    rst_n = 1'b0; vd = 1'b0; flush = 1'b0; cmd = 3'b000; op1 = 32'h0; op2 = 32'h0;
    vd8 = 1'b0; vd1 = 1'b0; flush64 = 1'b0; cmd64 = 3'b000; a64 = 64'h0; b64 = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (res !== 32'h0 || rdy !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_state res=%h rdy=%b busy=%b want 0 0 0", res, rdy, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      issue32(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Flush a DIV in cycle 10: no pulse ever, busy low from cycle 11, result held.
    @(negedge clk);
    cmd = 3'b100; op1 = 32'd1000; op2 = 32'd3; vd = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; vd = 1'b0;
    checks++;
    if (busy !== 1'b1 || rdy !== 1'b0) begin
      errors++; $display("FAIL flush_c10 busy=%b rdy=%b want 1 0", busy, rdy);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || rdy !== 1'b0 || res !== last_exp) begin
      errors++; $display("FAIL flush_c11 busy=%b rdy=%b res=%h want 0 0 %h", busy, rdy, res, last_exp);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rdy !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush_quiet got rdy/busy activity want none");
    end
    issue32(3'b000, 32'd3, 32'd5, 32'd15, 17);

    // Flush in the same cycle as a valid command in IDLE: nothing accepted.
    @(negedge clk);
    cmd = 3'b000; op1 = 32'd2; op2 = 32'd2; vd = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    vd = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_accept busy=%b want 0", busy);
    end

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    cmd = 3'b000; op1 = 32'd7; op2 = 32'd9; vd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res !== 32'h0 || rdy !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid res=%h rdy=%b busy=%b want 0 0 0", res, rdy, busy);
    end
    vd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue32(3'b011, 32'h80000000, 32'd2, 32'd1, 17);

    // Random sweep on the 64-bit instances.
    for (int i = 0; i < 32; i++) begin
      rc = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       rb = 64'd0;
        1:       begin ra = 64'h8000_0000_0000_0000; rb = 64'hFFFF_FFFF_FFFF_FFFF; end
        2:       rb = 64'($urandom_range(1, 15));
        3:       rb = rb >> $urandom_range(1, 60);
        default: rb = rb;
      endcase
      issue64(i[0], rc, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
